// File: rtl/mem_access_unit_if.sv
// Bundle for the MEM-stage load/store request, its response and the word-addressed data memory port.
// slave is the mem_access_unit side; master is the pipeline/memory environment side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        addr_exc;
    logic [2:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, is_load, is_store, size, ld_unsigned, addr, st_data, mem_dout,
        output stall, load_valid, load_data, addr_exc, mem_read, mem_write, mem_addr, mem_din
    );

    modport master (
        output req_valid, is_load, is_store, size, ld_unsigned, addr, st_data, mem_dout,
        input  stall, load_valid, load_data, addr_exc, mem_read, mem_write, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS MEM-stage load/store requester over a word-addressed synchronous memory, big-endian lanes.
// Optional macro LSU_RMW_EN: sub-word stores become read-modify-write instead of lane-coded writes.
module mem_access_unit (
    input  logic              i_clka,
    input  logic              i_reset,
    mem_access_unit_if.slave  io_bus
);
    localparam logic [2:0] C_WORD = 3'd0;
    localparam logic [2:0] C_HALF = 3'd1;
    localparam logic [2:0] C_BYTE = 3'd2;
    localparam logic [2:0] C_NONE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WAIT,
`ifdef LSU_RMW_EN
        S_RMW_RD,
        S_RMW_WR,
`endif
        S_LD_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_load_data_p1;
    logic        w_load_en;
    logic        w_err;

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] off, input logic uns);
        logic [15:0] half;
        logic [7:0]  b8;
        logic [31:0] res;
        half = off[1] ? word[15:0] : word[31:16];
        case (off)
            2'd0:    b8 = word[31:24];
            2'd1:    b8 = word[23:16];
            2'd2:    b8 = word[15:8];
            default: b8 = word[7:0];
        endcase
        case (sz)
            2'd1:    res = uns ? {16'h0000, half} : {{16{half[15]}}, half};
            2'd2:    res = uns ? {24'h000000, b8} : {{24{b8[7]}}, b8};
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef LSU_RMW_EN
    logic [31:0] r_merge_p1;
    logic        w_merge_en;

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] off, input logic [31:0] data);
        logic [31:0] res;
        res = word;
        if (sz == 2'd1) begin
            if (off[1]) res[15:0]  = data[15:0];
            else        res[31:16] = data[15:0];
        end else begin
            case (off)
                2'd0:    res[31:24] = data[7:0];
                2'd1:    res[23:16] = data[7:0];
                2'd2:    res[15:8]  = data[7:0];
                default: res[7:0]   = data[7:0];
            endcase
        end
        return res;
    endfunction
`endif

    assign w_err = io_bus.req_valid &&
                   ((io_bus.size == 2'd3) ||
                    (io_bus.size == 2'd0 && io_bus.addr[1:0] != 2'd0) ||
                    (io_bus.size == 2'd1 && io_bus.addr[0]) ||
                    (io_bus.is_load && io_bus.is_store) ||
                    (!io_bus.is_load && !io_bus.is_store));

    always_comb begin
        w_next           = r_state;
        w_load_en        = 1'b0;
`ifdef LSU_RMW_EN
        w_merge_en       = 1'b0;
`endif
        io_bus.stall     = 1'b0;
        io_bus.addr_exc  = 1'b0;
        io_bus.mem_read  = C_NONE;
        io_bus.mem_write = C_NONE;
        io_bus.mem_din   = '0;
        io_bus.mem_addr  = {2'b00, io_bus.addr[31:2]};
        case (r_state)
            S_IDLE: begin
                if (io_bus.req_valid) begin
                    if (w_err) begin
                        io_bus.addr_exc = 1'b1;
                    end else if (io_bus.is_load) begin
                        io_bus.mem_read = C_WORD;
                        io_bus.stall    = 1'b1;
                        w_next          = S_LD_WAIT;
                    end else if (io_bus.size == 2'd0) begin
                        io_bus.mem_write = C_WORD;
                        io_bus.mem_din   = io_bus.st_data;
                    end else begin
`ifdef LSU_RMW_EN
                        io_bus.mem_read = C_WORD;
                        io_bus.stall    = 1'b1;
                        w_next          = S_RMW_RD;
`else
                        io_bus.mem_write = (io_bus.size == 2'd1) ? C_HALF : C_BYTE;
                        io_bus.mem_din   = (io_bus.size == 2'd1) ? {io_bus.st_data[15:0], 16'h0000}
                                                                 : {io_bus.st_data[7:0], 24'h000000};
`endif
                    end
                end
            end
            // stage 1: read word returns, load lane is extended and captured
            S_LD_WAIT: begin
                io_bus.stall = 1'b1;
                w_load_en    = 1'b1;
                w_next       = S_LD_DONE;
            end
            // stage 2: result presented; the held request is ignored this cycle
            S_LD_DONE: begin
                w_next = S_IDLE;
            end
`ifdef LSU_RMW_EN
            S_RMW_RD: begin
                io_bus.stall = 1'b1;
                w_merge_en   = 1'b1;
                w_next       = S_RMW_WR;
            end
            S_RMW_WR: begin
                io_bus.mem_write = C_WORD;
                io_bus.mem_din   = r_merge_p1;
                w_next           = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
        if (i_reset) begin
            w_next           = S_IDLE;
            w_load_en        = 1'b0;
`ifdef LSU_RMW_EN
            w_merge_en       = 1'b0;
`endif
            io_bus.stall     = 1'b0;
            io_bus.addr_exc  = 1'b0;
            io_bus.mem_read  = C_NONE;
            io_bus.mem_write = C_NONE;
            io_bus.mem_din   = '0;
            io_bus.mem_addr  = '0;
        end
    end

    always_ff @(posedge i_clka) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_load_data_p1 <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_en)
                r_load_data_p1 <= extend_load(io_bus.mem_dout, io_bus.size, io_bus.addr[1:0],
                                              io_bus.ld_unsigned);
        end
    end

`ifdef LSU_RMW_EN
    // stage 1 of a sub-word store: merged word is held for the write-back cycle
    always_ff @(posedge i_clka) begin
        if (w_merge_en)
            r_merge_p1 <= merge_store(io_bus.mem_dout, io_bus.size, io_bus.addr[1:0], io_bus.st_data);
    end
`endif

    assign io_bus.load_valid = (r_state == S_LD_DONE) && !i_reset;
    assign io_bus.load_data  = r_load_data_p1;
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised self-checking bench for mem_access_unit against a byte-array big-endian memory model.
// Honours LSU_RMW_EN for the expected sub-word store behaviour.
module tb_mem_access_unit;
    localparam logic [2:0] C_WORD = 3'd0;
    localparam logic [2:0] C_HALF = 3'd1;
    localparam logic [2:0] C_BYTE = 3'd2;
    localparam logic [2:0] C_NONE = 3'd7;

    logic        clka = 1'b0;
    logic        reset;
    logic [31:0] v;
    logic [31:0] last_ld;
    logic [31:0] tb_mem [16];
    logic [7:0]  ref_mem [64];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clka = ~clka;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .i_clka (clka),
        .i_reset(reset),
        .io_bus (bus)
    );

    // synchronous word memory device: whole-word writes, one-cycle read latency
    always @(posedge clka) begin
        if (bus.mem_write != C_NONE) tb_mem[bus.mem_addr[3:0]] <= bus.mem_din;
        if (bus.mem_read == C_WORD)  bus.mem_dout <= tb_mem[bus.mem_addr[3:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic st, input logic [2:0] rd,
                           input logic [2:0] wr, input logic exc);
        check_eq({tag, "_stall"}, 32'(bus.stall), 32'(st));
        check_eq({tag, "_rd"}, 32'(bus.mem_read), 32'(rd));
        check_eq({tag, "_wr"}, 32'(bus.mem_write), 32'(wr));
        check_eq({tag, "_exc"}, 32'(bus.addr_exc), 32'(exc));
    endtask

    task automatic next_cycle();
        @(posedge clka);
        #1;
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'({a[5:2], 2'b00});
        return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int i;
        logic [15:0] h;
        logic [31:0] r;
        i = int'(a[5:0]);
        if (sz == 2'd0) begin
            r = ref_word(a);
        end else if (sz == 2'd1) begin
            h = {ref_mem[i], ref_mem[i+1]};
            r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
        end else begin
            r = uns ? {24'h000000, ref_mem[i]} : {{24{ref_mem[i][7]}}, ref_mem[i]};
        end
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int i;
        int b;
        i = int'(a[5:0]);
        b = int'({a[5:2], 2'b00});
        if (sz == 2'd0) begin
            for (int k = 0; k < 4; k++) ref_mem[b+k] = d[31-8*k -: 8];
        end else begin
`ifdef LSU_RMW_EN
            if (sz == 2'd1) begin
                ref_mem[i]   = d[15:8];
                ref_mem[i+1] = d[7:0];
            end else begin
                ref_mem[i] = d[7:0];
            end
`else
            for (int k = 0; k < 4; k++) ref_mem[b+k] = 8'h00;
            if (sz == 2'd1) begin
                ref_mem[b]   = d[15:8];
                ref_mem[b+1] = d[7:0];
            end else begin
                ref_mem[b] = d[7:0];
            end
`endif
        end
    endtask

    function automatic logic is_err(input logic ld, input logic st, input logic [1:0] sz,
                                    input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd0 && a[1:0] != 2'b00) return 1'b1;
        if (sz == 2'd1 && a[0]) return 1'b1;
        if (ld == st) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_req(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] d, output logic [31:0] ld_out);
        logic [31:0] exp_ld;
        logic [31:0] exp_din;
        ld_out          = '0;
        bus.req_valid   = 1'b1;
        bus.is_load     = ld;
        bus.is_store    = st;
        bus.size        = sz;
        bus.ld_unsigned = uns;
        bus.addr        = a;
        bus.st_data     = d;
        #4;
        check_eq("mem_addr", bus.mem_addr, {2'b00, a[31:2]});
        if (is_err(ld, st, sz, a)) begin
            chk_ctl("err", 1'b0, C_NONE, C_NONE, 1'b1);
        end else if (ld) begin
            exp_ld = ref_load(a, sz, uns);
            chk_ctl("ld_t0", 1'b1, C_WORD, C_NONE, 1'b0);
            next_cycle();
            #4;
            chk_ctl("ld_t1", 1'b1, C_NONE, C_NONE, 1'b0);
            check_eq("ld_t1_vld", 32'(bus.load_valid), 32'd0);
            next_cycle();
            #4;
            chk_ctl("ld_t2", 1'b0, C_NONE, C_NONE, 1'b0);
            check_eq("ld_t2_vld", 32'(bus.load_valid), 32'd1);
            check_eq("ld_data", bus.load_data, exp_ld);
            ld_out  = bus.load_data;
            last_ld = exp_ld;
        end else if (sz == 2'd0) begin
            ref_store(a, sz, d);
            chk_ctl("sw", 1'b0, C_NONE, C_WORD, 1'b0);
            check_eq("sw_din", bus.mem_din, d);
        end else begin
            ref_store(a, sz, d);
            exp_din = ref_word(a);
`ifdef LSU_RMW_EN
            chk_ctl("rmw_t0", 1'b1, C_WORD, C_NONE, 1'b0);
            next_cycle();
            #4;
            chk_ctl("rmw_t1", 1'b1, C_NONE, C_NONE, 1'b0);
            next_cycle();
            #4;
            chk_ctl("rmw_t2", 1'b0, C_NONE, C_WORD, 1'b0);
            check_eq("rmw_din", bus.mem_din, exp_din);
`else
            chk_ctl("ssub", 1'b0, C_NONE, (sz == 2'd1) ? C_HALF : C_BYTE, 1'b0);
            check_eq("ssub_din", bus.mem_din, exp_din);
`endif
        end
        next_cycle();
    endtask

    task automatic idle_cycle();
        bus.req_valid = 1'b0;
        bus.is_load   = 1'($urandom_range(0, 1));
        bus.is_store  = 1'($urandom_range(0, 1));
        bus.size      = 2'($urandom_range(0, 3));
        bus.addr      = $urandom;
        #4;
        chk_ctl("idle", 1'b0, C_NONE, C_NONE, 1'b0);
        check_eq("idle_vld", 32'(bus.load_valid), 32'd0);
        check_eq("idle_ldata", bus.load_data, last_ld);
        next_cycle();
    endtask

    task automatic reset_during(input logic ld, input logic [31:0] a);
        bus.req_valid   = 1'b1;
        bus.is_load     = ld;
        bus.is_store    = !ld;
        bus.size        = ld ? 2'd0 : 2'd2;
        bus.ld_unsigned = 1'b0;
        bus.addr        = a;
        bus.st_data     = 32'h000000AB;
        #4;
        chk_ctl("rst_acc", 1'b1, C_WORD, C_NONE, 1'b0);
        next_cycle();
        reset = 1'b1;
        #4;
        chk_ctl("rst_cyc", 1'b0, C_NONE, C_NONE, 1'b0);
        check_eq("rst_cyc_vld", 32'(bus.load_valid), 32'd0);
        next_cycle();
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        last_ld       = '0;
        repeat (3) idle_cycle();
    endtask

    initial begin
        reset           = 1'b1;
        last_ld         = '0;
        bus.req_valid   = 1'b0;
        bus.is_load     = 1'b0;
        bus.is_store    = 1'b0;
        bus.size        = 2'd0;
        bus.ld_unsigned = 1'b0;
        bus.addr        = '0;
        bus.st_data     = '0;
        next_cycle();
        #4;
        chk_ctl("reset", 1'b0, C_NONE, C_NONE, 1'b0);
        check_eq("reset_vld", 32'(bus.load_valid), 32'd0);
        check_eq("reset_ldata", bus.load_data, 32'd0);
        next_cycle();
        reset = 1'b0;

        for (int w = 0; w < 16; w++) run_req(1'b0, 1'b1, 2'd0, 1'b0, 32'(w * 4), $urandom, v);

        run_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h10, 32'hDEADBEEF, v);
        run_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, v);
        check_eq("tp_word", v, 32'hDEADBEEF);

        run_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h10, 32'h11223344, v);
        run_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h12, 32'h000000AB, v);
        run_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, v);
`ifdef LSU_RMW_EN
        check_eq("tp_rmw_byte", v, 32'h1122AB44);
`else
        check_eq("tp_sub_byte", v, 32'hAB000000);
`endif

        run_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h10, 32'h80FF7F01, v);
        run_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h11, 32'h0, v);
        check_eq("tp_lb", v, 32'hFFFFFFFF);
        run_req(1'b1, 1'b0, 2'd2, 1'b1, 32'h11, 32'h0, v);
        check_eq("tp_lbu", v, 32'h000000FF);
        run_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, v);
        check_eq("tp_lh0", v, 32'hFFFF80FF);
        run_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, v);
        check_eq("tp_lh2", v, 32'h00007F01);
        idle_cycle();

        run_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, v);
        run_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, v);
        run_req(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, v);
        run_req(1'b1, 1'b1, 2'd0, 1'b0, 32'h10, 32'h0, v);
        run_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, v);
        idle_cycle();

        run_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h0000BEEF, v);
        run_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, v);
`ifdef LSU_RMW_EN
        check_eq("tp_sh", v, 32'hBEEF7F01);
`else
        check_eq("tp_sh", v, 32'hBEEF0000);
`endif

        run_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h10, 32'h11223344, v);
`ifdef LSU_RMW_EN
        reset_during(1'b0, 32'h12);
        run_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, v);
        check_eq("tp_rst_rmw", v, 32'h11223344);
`endif
        reset_during(1'b1, 32'h10);
        run_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, v);
        check_eq("tp_rst_ld", v, 32'h11223344);

        for (int n = 0; n < 300; n++) begin
            logic        ld;
            logic        st;
            logic [1:0]  sz;
            logic [31:0] a;
            int          sel;
            sel = int'($urandom_range(0, 9));
            sz  = (sel == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ld  = 1'($urandom_range(0, 1));
            st  = (sel == 1) ? ld : !ld;
            a   = $urandom;
            if (sel > 3) begin
                if (sz == 2'd0) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0] = 1'b0;
            end
            run_req(ld, st, sz, 1'($urandom_range(0, 1)), a, $urandom, v);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
